// File: rtl/quad_decoder.sv
// Quadrature decoder: two-flop synchronizers, a debounce filter on the AB
// pair, and a Gray-sequence state machine that drives a 4-bit position
// counter with wrap, direction and sticky illegal-transition reporting.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | no baseline yet; the first accepted pair is taken silently
//   S00   | accepted AB = 00
//   S10   | accepted AB = 10
//   S11   | accepted AB = 11
//   S01   | accepted AB = 01
module quad_decoder #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       load,
  input  logic [3:0] data,
  input  logic       clr_err,
  output logic       step,
  output logic       up_down,
  output logic [3:0] count,
  output logic       wrap,
  output logic       error
);

  typedef enum logic [2:0] {INIT, S00, S10, S11, S01} state_t;

  localparam logic [3:0] FILT_TC = 4'(FILT_LEN);

  logic [1:0] sync_a_q, sync_b_q;
  logic [1:0] prime_q;
  logic [1:0] ab_sync;

  logic [1:0] cand_q, cand_d;
  logic [1:0] acc_q, acc_d;
  logic [3:0] rem_q, rem_d;
  logic       base_q, base_d;
  logic       acc_stb_q, acc_stb_d;

  state_t     state_q;
  state_t     tgt;
  logic       is_up, is_dn, is_bad;
  logic       step_q, up_down_q, wrap_q, error_q;
  logic [3:0] count_q;

  function automatic state_t pair_state(input logic [1:0] ab);
    case (ab)
      2'b00:   return S00;
      2'b10:   return S10;
      2'b11:   return S11;
      default: return S01;
    endcase
  endfunction

  function automatic state_t up_next(input state_t s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      S01:     return S00;
      default: return INIT;
    endcase
  endfunction

  function automatic state_t dn_next(input state_t s);
    case (s)
      S00:     return S01;
      S01:     return S11;
      S11:     return S10;
      S10:     return S00;
      default: return INIT;
    endcase
  endfunction

  assign ab_sync = {sync_a_q[1], sync_b_q[1]};

  // Two-flop synchronizers; prime_q marks when the second stage holds a real sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q <= 2'b00;
      sync_b_q <= 2'b00;
      prime_q  <= 2'b00;
    end else begin
      sync_a_q <= {sync_a_q[0], quad_a};
      sync_b_q <= {sync_b_q[0], quad_b};
      prime_q  <= {prime_q[0], 1'b1};
    end
  end

  // Debounce: rem counts down the samples still needed before the candidate is accepted.
  always_comb begin
    cand_d    = cand_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    base_d    = base_q;
    acc_stb_d = 1'b0;
    if (prime_q[1]) begin
      if (!base_q || (ab_sync != acc_q)) begin
        if ((rem_q != 4'd0) && (ab_sync == cand_q)) begin
          if (rem_q == 4'd1) begin
            acc_d     = ab_sync;
            base_d    = 1'b1;
            acc_stb_d = 1'b1;
            rem_d     = 4'd0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end else begin
          cand_d = ab_sync;
          if (FILT_TC == 4'd1) begin
            acc_d     = ab_sync;
            base_d    = 1'b1;
            acc_stb_d = 1'b1;
            rem_d     = 4'd0;
          end else begin
            rem_d = FILT_TC - 4'd1;
          end
        end
      end else begin
        rem_d = 4'd0;
      end
    end
  end

  // Filter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q    <= 2'b00;
      acc_q     <= 2'b00;
      rem_q     <= 4'd0;
      base_q    <= 1'b0;
      acc_stb_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      base_q    <= base_d;
      acc_stb_q <= acc_stb_d;
    end
  end

  // Classify a freshly accepted pair against the current state.
  always_comb begin
    tgt    = pair_state(acc_q);
    is_up  = acc_stb_q && (state_q != INIT) && (tgt == up_next(state_q));
    is_dn  = acc_stb_q && (state_q != INIT) && (tgt == dn_next(state_q));
    is_bad = acc_stb_q && (state_q != INIT) && !is_up && !is_dn;
  end

  // State machine with registered step/direction/count/wrap/error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      step_q    <= 1'b0;
      up_down_q <= 1'b0;
      count_q   <= 4'd0;
      wrap_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (acc_stb_q) begin
        state_q <= tgt;
      end
      step_q <= is_up | is_dn;
      if (is_up | is_dn) begin
        up_down_q <= is_up;
      end
      // load overrides the step's count update and suppresses wrap
      if (load) begin
        count_q <= data;
        wrap_q  <= 1'b0;
      end else if (is_up) begin
        count_q <= count_q + 4'd1;
        wrap_q  <= (count_q == 4'd15);
      end else if (is_dn) begin
        count_q <= count_q - 4'd1;
        wrap_q  <= (count_q == 4'd0);
      end else begin
        wrap_q <= 1'b0;
      end
      // a new illegal transition beats a simultaneous clear
      if (is_bad) begin
        error_q <= 1'b1;
      end else if (clr_err) begin
        error_q <= 1'b0;
      end
    end
  end

  assign step    = step_q;
  assign up_down = up_down_q;
  assign count   = count_q;
  assign wrap    = wrap_q;
  assign error   = error_q;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILT_LEN, default 3, gives the number of consecutive identical synchronized samples required before a quadrature level is accepted (legal range 1-15).
REQ-002 Port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port quad_a, input, 1 bit: asynchronous quadrature channel A.
REQ-005 Port quad_b, input, 1 bit: asynchronous quadrature channel B.
REQ-006 Port load, input, 1 bit: synchronous load of count from data.
REQ-007 Port data, input, 4 bits: load value.
REQ-008 Port clr_err, input, 1 bit: synchronous clear of error.
REQ-009 Port step, output, 1 bit: one-cycle pulse per legal quadrature transition.
REQ-010 Port up_down, output, 1 bit: direction of the last legal step (1 = up, 0 = down).
REQ-011 Port count, output, 4 bits: position counter.
REQ-012 Port wrap, output, 1 bit: one-cycle pulse when count wraps.
REQ-013 Port error, output, 1 bit: sticky illegal-transition flag.

Function
REQ-014 Each quadrature input SHALL pass through a two-flop synchronizer before any other use.
REQ-015 The filter SHALL accept a new AB pair only after FILT_LEN consecutive identical synchronized samples that differ from the accepted pair.
- Any differing sample restarts the run count.
REQ-016 The state machine SHALL have states INIT, S00, S10, S11 and S01, where each Sxy encodes the accepted AB pair.
REQ-017 INIT SHALL take the first accepted pair as its baseline and move to the matching Sxy, with no step and no error.
REQ-018 The up sequence SHALL be S00->S10->S11->S01->S00 (A leads B); the reverse order SHALL be down.
REQ-019 On a legal transition, the decoder SHALL:
- pulse step high for exactly one cycle;
- update up_down in that same cycle;
- leave up_down unchanged otherwise.
REQ-020 A new accepted pair that differs from the current state in both bits SHALL:
- set error;
- move the state to the new pair;
- produce no step and no count change.
REQ-021 Latency SHALL be FILT_LEN+3 clock edges from the first edge that samples a new stable input level to the cycle in which step is high.
REQ-022 Count update rules:
- up step: count+1 modulo 16;
- down step: count-1 modulo 16;
- no step: hold.
REQ-023 wrap SHALL pulse in the same cycle as the count update on 15->0 (up) and 0->15 (down).
REQ-024 When load and step occur in the same cycle, load SHALL win:
- count becomes data;
- wrap stays low;
- step and up_down are still reported.
REQ-025 error SHALL stay set until clr_err is asserted; if a new illegal transition coincides with clr_err, error SHALL remain set.

Reset
REQ-026 While reset is high, and immediately on its assertion (without waiting for clk), the block SHALL set the following, then hold all of it until reset deasserts:
- step=0, up_down=0, count=0, wrap=0, error=0;
- synchronizers and filter run count cleared;
- state = INIT.
REQ-027 Reset asserted mid-operation SHALL discard any partially filtered level; after reset the next accepted pair is a silent baseline (REQ-017).

Verification
REQ-028 Reset release with AB=11 held -> no step and no error; state S11, count=0.
REQ-029 FILT_LEN=3, four up transitions each held 10 cycles, starting from S00 -> four step pulses, each 6 edges after its input change; up_down=1, count=4.
REQ-030 count=0, one down transition -> count=15, wrap=1 for one cycle, up_down=0.
REQ-031 A glitch held for FILT_LEN-1 cycles, then returning to the original level -> no step and no count change.
REQ-032 From S00, AB jumps to 11 and is held stable -> error=1, no step, state S11; pulse clr_err -> error=0 on the next cycle.
REQ-033 load=1, data=9 in the same cycle as an up step with count=15 -> count=9, wrap=0, step=1, up_down=1.
